light_sequencer: RTL

//  Controller for the lights selector datapath (sel/button/light). Drives the selector's sel,

---
 rtl/light_sequencer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/light_sequencer.sv
// Automatic RGB sequencer driving the lights selector's sel / step (button) / colour-reset lines.
// Inputs pass a 2-FF sync plus rising-edge detect (2 clocks); all outputs registered, 1 clock.
// No backpressure: events are acted on immediately, priority stop > pause > step. Optional input
// debouncer enabled by defining LIGHT_SEQ_DEBOUNCE_EN.
module light_sequencer #(
    parameter int DWELL_CYCLES    = 8,
    parameter int NUM_COLOURS     = 6,
    parameter int LOOPS           = 2,
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       man_step,
    output logic       sel,
    output logic       button,
    output logic       lights_rst,
    output logic [2:0] colour_idx,
    output logic [7:0] loop_cnt,
    output logic       busy,
    output logic       done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [2:0]       COL_LAST = 3'(NUM_COLOURS - 1);
    localparam logic [8:0]       LOOP_TGT = 9'(LOOPS);
    localparam bit               LOOP_EN  = (LOOPS != 0);

    // Reject configurations the counters cannot represent.
    generate
        if (DWELL_CYCLES < 2 || NUM_COLOURS < 1 || NUM_COLOURS > 8 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
            $error("light_sequencer: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;

    // Input bit order: 0 start, 1 stop, 2 pause, 3 man_step.
    logic [3:0]       w_raw;
    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_prev;
    logic [3:0]       w_lvl;
    logic [3:0]       w_edge;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [2:0]       w_col_nx;
    logic [7:0]       w_loop_nx;
    logic             w_sel_nx;
    logic             w_btn_nx;
    logic             w_lrst_nx;
    logic             w_busy_nx;
    logic             w_done_nx;
    logic             w_pulse;
    logic             w_advance;
    logic             w_wrap;
    logic             w_final;

    assign w_raw = {man_step, pause, stop, start};

    // Two-flop synchroniser and previous-level register for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_prev  <= w_lvl;
        end
    end

`ifdef LIGHT_SEQ_DEBOUNCE_EN
    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0] r_db_cnt [4];
    logic [3:0]      r_db_lvl;

    // A new level is accepted only after it differs from the held level for DEBOUNCE_CYCLES clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
            r_db_lvl <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_db_lvl[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db_lvl[i] <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_lvl = r_db_lvl;
`else
    assign w_lvl = r_sync2;
`endif

    assign w_edge  = w_lvl & ~r_prev;
    assign w_wrap  = (colour_idx == COL_LAST);
    assign w_final = LOOP_EN && w_wrap && (({1'b0, loop_cnt} + 9'd1) == LOOP_TGT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state plus step/advance decisions; a terminal count coinciding with pause defers the pulse.
    always_comb begin
        w_next    = r_state;
        w_pulse   = 1'b0;
        w_advance = 1'b0;
        unique case (r_state)
            S_IDLE:  if (w_edge[0]) w_next = S_LOAD;
            S_LOAD:  w_next = w_edge[1] ? S_IDLE : S_RUN;
            S_RUN: begin
                if (w_edge[1])            w_next = S_IDLE;
                else if (w_edge[2])       w_next = S_PAUSE;
                else if (r_cnt == CNT_LAST) begin
                    w_pulse = 1'b1;
                    if (w_final) w_next = S_DONE;
                end else                  w_advance = 1'b1;
            end
            S_PAUSE: begin
                if (w_edge[1])            w_next = S_IDLE;
                else if (w_edge[2])       w_next = S_RUN;
                else if (w_edge[3]) begin
                    w_pulse = 1'b1;
                    if (w_final) w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and dwell counter, derived from the upcoming state.
    always_comb begin
        w_cnt_nx  = r_cnt;
        w_col_nx  = colour_idx;
        w_loop_nx = loop_cnt;
        w_sel_nx  = (w_next != S_IDLE);
        w_busy_nx = (w_next != S_IDLE);
        w_lrst_nx = (w_next == S_IDLE) || (w_next == S_LOAD);
        w_btn_nx  = w_pulse;
        w_done_nx = (r_state == S_DONE);
        if (w_next == S_LOAD) begin
            w_cnt_nx  = '0;
            w_col_nx  = '0;
            w_loop_nx = '0;
        end else if (w_advance) begin
            w_cnt_nx = r_cnt + 1'b1;
        end else if (w_pulse) begin
            // A manual step in PAUSE leaves the frozen dwell count untouched.
            if (r_state == S_RUN) w_cnt_nx = '0;
            if (w_wrap) begin
                w_col_nx  = '0;
                w_loop_nx = (loop_cnt == 8'hFF) ? loop_cnt : loop_cnt + 8'd1;
            end else begin
                w_col_nx  = colour_idx + 3'd1;
            end
        end
    end

    // Output and dwell-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            sel        <= 1'b0;
            button     <= 1'b0;
            lights_rst <= 1'b1;
            colour_idx <= '0;
            loop_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nx;
            sel        <= w_sel_nx;
            button     <= w_btn_nx;
            lights_rst <= w_lrst_nx;
            colour_idx <= w_col_nx;
            loop_cnt   <= w_loop_nx;
            busy       <= w_busy_nx;
            done       <= w_done_nx;
        end
    end

endmodule
